// File: rtl/threshold_ctrl_pkg.sv
// Shared constants, state codes and the threshold clamp for the binarisation threshold sequencer.
package threshold_ctrl_pkg;

    localparam int PIX_W       = 12;
    localparam int TH_MAX      = 4095;
    localparam int DEF_INIT_TH = 947;
    localparam int DEF_STEP    = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] DIVIDE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Mean plus signed offset can leave the pixel range in either direction.
    function automatic logic [PIX_W-1:0] clampTh(input logic signed [13:0] v);
        logic [PIX_W-1:0] r;
        if (v < 14'sd0)
            r = '0;
        else if (v > 14'sd4095)
            r = PIX_W'(TH_MAX);
        else
            r = v[PIX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/threshold_ctrl_seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle.
// Latency: done pulses SUM_W+1 cycles after start (SUM_W steps plus one registered cycle).
// No backpressure: start reloads the operands, abort cancels immediately without a done pulse.
module seq_divider #(
    parameter int SUM_W = 36,
    parameter int CNT_W = 24
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             start,
    input  logic             abort,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int STEP_W = $clog2(SUM_W + 1);

    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  dvsr;
    logic [STEP_W-1:0] stepsLeft;
    logic [CNT_W:0]    shifted;
    logic [CNT_W:0]    diff;
    logic              fits;

    // rem < dvsr always, so the top bit of diff is a clean borrow flag.
    assign shifted = {rem, quotient[SUM_W-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign fits    = ~diff[CNT_W];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rem       <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            stepsLeft <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                busy      <= 1'b1;
                rem       <= '0;
                dvsr      <= divisor;
                quotient  <= dividend;
                stepsLeft <= STEP_W'(SUM_W);
            end else if (busy) begin
                rem       <= fits ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
                quotient  <= {quotient[SUM_W-2:0], fits};
                stepsLeft <= stepsLeft - 1'b1;
                if (stepsLeft == STEP_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/threshold_ctrl.sv
// Frame-synchronous binarisation threshold: manual key stepping or previous-frame mean plus offset.
// Latency: oTHRESH loads the cycle after frame start; the auto result is ready SUM_W+2 cycles after frame end.
// No backpressure: the gray stream is only tapped, never stalled.
module threshold_ctrl
    import threshold_ctrl_pkg::*;
#(
    parameter int                 INIT_TH = DEF_INIT_TH,
    parameter int                 STEP    = DEF_STEP,
    parameter logic signed [12:0] OFFSET  = 13'sd0,
    parameter int                 CNT_W   = 24,
    parameter int                 SUM_W   = 36
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    input  logic        iMODE,
    input  logic        iKEY_UP,
    input  logic        iKEY_DN,
    output logic [11:0] oTHRESH,
    output logic        oUPDATE,
    output logic [11:0] oMEAN,
    output logic        oBUSY
);

    logic              fvalD;
    logic              fs;
    logic              fe;
    logic              pixVld;
    logic [1:0]        state;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;
    logic [PIX_W-1:0]  manTh;
    logic [PIX_W-1:0]  autoTh;
    logic [PIX_W-1:0]  meanQ;
    logic [PIX_W:0]    manUp;
    logic signed [13:0] autoSum;
    logic              divStart;
    logic              divAbort;
    logic              divBusy;
    logic              divDone;
    logic [SUM_W-1:0]  quotient;

    assign fs       = iFVAL & ~fvalD;
    assign fe       = ~iFVAL & fvalD;
    assign pixVld   = iFVAL & iDVAL;
    assign divStart = (state == ACCUM) & fe & (cnt != '0);
    assign divAbort = (state == DIVIDE) & fs;
    assign oBUSY    = divBusy | divDone;

    // The quotient cannot exceed the largest pixel, but saturate rather than truncate if it ever did.
    assign meanQ   = (quotient[SUM_W-1:PIX_W] != '0) ? PIX_W'(TH_MAX) : quotient[PIX_W-1:0];
    assign autoSum = $signed({2'b00, meanQ}) + $signed({OFFSET[12], OFFSET});
    assign manUp   = {1'b0, manTh} + (PIX_W+1)'(STEP);

    seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) uDiv (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .start    (divStart),
        .abort    (divAbort),
        .dividend (sum),
        .divisor  (cnt),
        .busy     (divBusy),
        .done     (divDone),
        .quotient (quotient)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalD <= 1'b0;
            manTh <= PIX_W'(INIT_TH);
        end else begin
            fvalD <= iFVAL;
            if (iKEY_UP & ~iKEY_DN)
                manTh <= (manUp > (PIX_W+1)'(TH_MAX)) ? PIX_W'(TH_MAX) : manUp[PIX_W-1:0];
            else if (iKEY_DN & ~iKEY_UP)
                manTh <= (manTh < PIX_W'(STEP)) ? '0 : manTh - PIX_W'(STEP);
        end
    end

    // Registered sources are sampled here, so a key in the fs cycle waits for the next frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oTHRESH <= PIX_W'(INIT_TH);
            oUPDATE <= 1'b0;
        end else begin
            oUPDATE <= fs;
            if (fs)
                oTHRESH <= iMODE ? autoTh : manTh;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            sum    <= '0;
            cnt    <= '0;
            oMEAN  <= '0;
            autoTh <= PIX_W'(INIT_TH);
        end else if (fs) begin
            // A pixel arriving with frame start belongs to the new frame.
            state <= ACCUM;
            sum   <= pixVld ? SUM_W'(iDATA) : '0;
            cnt   <= pixVld ? CNT_W'(1) : '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (fe)
                        state <= (cnt == '0) ? IDLE : DIVIDE;
                    else if (pixVld && !(&cnt)) begin
                        sum <= sum + SUM_W'(iDATA);
                        cnt <= cnt + 1'b1;
                    end
                end
                DIVIDE: begin
                    if (divDone) begin
                        oMEAN  <= meanQ;
                        autoTh <= clampTh(autoSum);
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_ctrl.sv
// Randomized bench for threshold_ctrl: three offsets share one stimulus stream against a frame-level model.
module tb_threshold_ctrl;

    localparam int SUM_W   = 36;
    localparam int INIT_TH = 947;
    localparam int NDUT    = 3;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFVAL, iDVAL, iMODE, iKEY_UP, iKEY_DN;
    logic [11:0] iDATA;
    logic [11:0] thr  [NDUT];
    logic [11:0] mean [NDUT];
    logic        upd  [NDUT];
    logic        busy [NDUT];

    always #5 iCLK = ~iCLK;

    threshold_ctrl #(.OFFSET(13'sd0)) u0 (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA), .iMODE(iMODE),
        .iKEY_UP(iKEY_UP), .iKEY_DN(iKEY_DN),
        .oTHRESH(thr[0]), .oUPDATE(upd[0]), .oMEAN(mean[0]), .oBUSY(busy[0]));
    threshold_ctrl #(.OFFSET(13'sd64)) u1 (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA), .iMODE(iMODE),
        .iKEY_UP(iKEY_UP), .iKEY_DN(iKEY_DN),
        .oTHRESH(thr[1]), .oUPDATE(upd[1]), .oMEAN(mean[1]), .oBUSY(busy[1]));
    threshold_ctrl #(.OFFSET(-13'sd64)) u2 (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA), .iMODE(iMODE),
        .iKEY_UP(iKEY_UP), .iKEY_DN(iKEY_DN),
        .oTHRESH(thr[2]), .oUPDATE(upd[2]), .oMEAN(mean[2]), .oBUSY(busy[2]));

    int checks   = 0;
    int failures = 0;
    int offs [NDUT] = '{0, 64, -64};
    int manM;
    int autoM   [NDUT];
    int threshM [NDUT];
    int meanM;
    int pixQ [$];
    int lastN;
    bit modeSel;
    bit randKeys;
    bit forceFsUp;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampM(input int v);
        return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic applyKey();
        int r;
        r = randKeys ? $urandom_range(0, 15) : 15;
        iKEY_UP = (r == 0 || r == 2);
        iKEY_DN = (r == 1 || r == 2);
    endtask

    task automatic modelKey();
        if (iKEY_UP && !iKEY_DN)
            manM = (manM + 16 > 4095) ? 4095 : manM + 16;
        else if (iKEY_DN && !iKEY_UP)
            manM = (manM < 16) ? 0 : manM - 16;
    endtask

    task automatic checkSteady();
        for (int d = 0; d < NDUT; d++) begin
            checkVal("hold_update", upd[d], 0);
            checkVal("hold_thresh", thr[d], threshM[d]);
        end
    endtask

    task automatic checkGap(input bit busyExp);
        for (int d = 0; d < NDUT; d++) begin
            checkVal("busy", busy[d], busyExp);
            checkVal("mean", mean[d], meanM);
        end
    endtask

    task automatic doReset();
        iRST = 1'b0;
        iFVAL = 0; iDVAL = 0; iKEY_UP = 0; iKEY_DN = 0; iMODE = 0; iDATA = '0;
        #2;
        manM = INIT_TH;
        meanM = 0;
        for (int d = 0; d < NDUT; d++) begin
            autoM[d] = INIT_TH;
            threshM[d] = INIT_TH;
            checkVal("rst_thresh", thr[d], INIT_TH);
            checkVal("rst_mean", mean[d], 0);
            checkVal("rst_update", upd[d], 0);
            checkVal("rst_busy", busy[d], 0);
        end
        tick();
        tick();
        iRST = 1'b1;
        tick();
        checkSteady();
        checkGap(0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            iFVAL = 0; iDVAL = 0; iKEY_UP = 0; iKEY_DN = 0;
            tick();
            checkSteady();
            checkGap(0);
        end
    endtask

    task automatic keyCycle(input bit up, input bit dn);
        iFVAL = 0; iDVAL = 0; iKEY_UP = up; iKEY_DN = dn;
        modelKey();
        tick();
        iKEY_UP = 0; iKEY_DN = 0;
        checkSteady();
        checkGap(0);
    endtask

    // One frame: fs, pixels from pixQ with random bubbles, one trailing active cycle, then `gap` blank cycles.
    task automatic runFrame(input int gap, input bit fsPix);
        int sum, n, v;
        sum = 0;
        n = 0;
        iFVAL = 1;
        iMODE = modeSel;
        applyKey();
        if (forceFsUp) begin
            iKEY_UP = 1; iKEY_DN = 0;
        end
        if (fsPix && pixQ.size() > 0) begin
            v = pixQ.pop_front();
            iDVAL = 1; iDATA = 12'(v); sum += v; n++;
        end else begin
            iDVAL = 0; iDATA = 12'($urandom);
        end
        for (int d = 0; d < NDUT; d++)
            threshM[d] = modeSel ? autoM[d] : manM;
        modelKey();
        tick();
        for (int d = 0; d < NDUT; d++) begin
            checkVal("fs_update", upd[d], 1);
            checkVal("fs_thresh", thr[d], threshM[d]);
        end
        while (pixQ.size() > 0) begin
            iMODE = 1'($urandom);
            applyKey();
            if ($urandom_range(0, 3) != 0) begin
                v = pixQ.pop_front();
                iDVAL = 1; iDATA = 12'(v); sum += v; n++;
            end else begin
                iDVAL = 0; iDATA = 12'($urandom);
            end
            modelKey();
            tick();
            checkSteady();
        end
        iDVAL = 0;
        applyKey();
        modelKey();
        tick();
        checkSteady();
        for (int j = 0; j < gap; j++) begin
            iFVAL = 0;
            iDVAL = 1'($urandom);
            iDATA = 12'($urandom);
            applyKey();
            modelKey();
            tick();
            checkSteady();
            if (n > 0 && j == SUM_W + 1) begin
                meanM = sum / n;
                for (int d = 0; d < NDUT; d++)
                    autoM[d] = clampM(meanM + offs[d]);
            end
            checkGap(n > 0 && j <= SUM_W);
        end
        lastN = n;
    endtask

    task automatic fillRand(input int n);
        for (int k = 0; k < n; k++)
            pixQ.push_back($urandom_range(0, 4095));
    endtask

    task automatic fillConst(input int n, input int v);
        for (int k = 0; k < n; k++)
            pixQ.push_back(v);
    endtask

    initial begin
        int prevGap, g, sel;
        bit fp;
        randKeys = 0;
        forceFsUp = 0;
        modeSel = 0;
        lastN = 0;
        iRST = 1'b1;
        #1;
        doReset();
        idleCycles(300);

        // Manual stepping and saturation.
        for (int i = 0; i < 3; i++) keyCycle(1, 0);
        runFrame(5, 0);
        checkVal("man_up3", thr[0], 995);
        keyCycle(1, 1);
        runFrame(5, 0);
        for (int i = 0; i < 70; i++) keyCycle(0, 1);
        runFrame(5, 0);
        checkVal("man_sat0", thr[0], 0);
        forceFsUp = 1;
        runFrame(5, 0);
        forceFsUp = 0;
        checkVal("man_fs_key_late", thr[0], 0);
        runFrame(5, 0);
        checkVal("man_fs_key_next", thr[0], 16);
        for (int i = 0; i < 300; i++) keyCycle(1, 0);
        runFrame(5, 0);
        checkVal("man_sat4095", thr[0], 4095);

        // Auto mean and clamping.
        modeSel = 1;
        pixQ = '{100, 200, 300, 400};
        runFrame(45, 0);
        checkVal("auto_mean250", mean[0], 250);
        runFrame(45, 0);
        checkVal("auto_th250", thr[0], 250);
        fillConst(20, 4095);
        runFrame(45, 0);
        runFrame(45, 0);
        checkVal("clamp_hi", thr[1], 4095);
        fillConst(20, 10);
        runFrame(45, 0);
        runFrame(45, 0);
        checkVal("clamp_lo", thr[2], 0);
        runFrame(45, 0);
        checkVal("empty_reload", thr[2], 0);

        // Aborted divides, including the last DIVIDE cycle and the DONE collision.
        fillRand(8);
        runFrame(5, 0);
        fillRand(6);
        runFrame(45, 1);
        runFrame(45, 0);
        fillRand(9);
        runFrame(37, 0);
        fillRand(7);
        runFrame(38, 1);
        runFrame(45, 0);

        // Random frames, modes, keys and gaps.
        randKeys = 1;
        prevGap = 45;
        for (int f = 0; f < 24; f++) begin
            modeSel = 1'($urandom);
            fillRand($urandom_range(0, 24));
            sel = $urandom_range(0, 3);
            g = (sel == 0) ? $urandom_range(1, 8) :
                (sel == 1) ? $urandom_range(35, 40) : 45;
            fp = (prevGap <= 37 && lastN > 0) ? 1'($urandom) : 1'b0;
            runFrame(g, fp);
            prevGap = g;
        end
        randKeys = 0;
        runFrame(45, 0);

        // Reset in the middle of a divide.
        modeSel = 1;
        fillRand(10);
        runFrame(10, 0);
        doReset();
        runFrame(45, 0);
        checkVal("post_rst_thresh", thr[0], INIT_TH);
        idleCycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/threshold_ctrl.md
Name: threshold_ctrl

Overview:
Sequences the binarisation threshold used by the gray-to-binary stage of the capture pipeline. It supports two modes: manual stepping from debounced key pulses, and auto mode, where the threshold is derived from the previous frame's mean gray level plus an offset. The threshold output changes only at frame start, so the binariser never sees a threshold change mid-frame. It sits beside the gray-to-binary stage, taps the same 12-bit gray stream, and drives that stage's threshold input.

Parameters:
INIT_TH, 947, threshold after reset; also the initial manual and auto values
STEP, 16, manual increment/decrement per key pulse
OFFSET, 0, signed 13-bit value added to the frame mean in auto mode
CNT_W, 24, pixel counter width
SUM_W, 36, accumulator width (12 + CNT_W)

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-low
iFVAL  in  1  frame valid; high during the active frame
iDVAL  in  1  pixel valid
iDATA  in  12  gray pixel
iMODE  in  1  0 = manual, 1 = auto; sampled at frame start
iKEY_UP  in  1  one-cycle pulse, already debounced
iKEY_DN  in  1  one-cycle pulse, already debounced
oTHRESH  out  12  threshold applied to the binariser
oUPDATE  out  1  one-cycle pulse when oTHRESH is loaded
oMEAN  out  12  last computed frame mean
oBUSY  out  1  high while the divider runs

Behaviour:
- Reset (async, iRST low): oTHRESH = man_th = auto_th = INIT_TH; oMEAN = 0; oUPDATE = 0; oBUSY = 0; sum = cnt = 0; state = IDLE; fval_d = 0.
- Edge detection: fval_d is iFVAL registered. Frame start (fs) = iFVAL & ~fval_d. Frame end (fe) = ~iFVAL & fval_d.
- Manual register man_th:
  - iKEY_UP alone adds STEP, saturating at 4095.
  - iKEY_DN alone subtracts STEP, saturating at 0.
  - Both or neither: no change.
  - Keys are honoured in both modes.
- States:
  - IDLE: on fs, clear sum/cnt and go to ACCUM.
  - ACCUM: each cycle with iFVAL & iDVAL, sum += iDATA and cnt += 1. If cnt is all-ones, both freeze (saturation, no wrap). On fe: if cnt == 0, go to IDLE with auto_th unchanged; otherwise start the divider and go to DIVIDE.
  - DIVIDE: oBUSY = 1. The restoring divider computes q = floor(sum/cnt) in SUM_W cycles, plus 1 cycle to register the result, then go to DONE.
    - fs during DIVIDE: abort, discard the result, keep auto_th, clear sum/cnt, go to ACCUM. The pixel at the fs cycle is counted.
  - DONE (1 cycle): oMEAN = q[11:0] (q ≤ 4095 by construction). auto_th = clamp(q + OFFSET, 0, 4095), computed in 14-bit signed arithmetic. Go to IDLE. An fs arriving in DONE is handled as in IDLE on the next cycle; the DONE result is still committed first.
- Threshold load: on fs in any state, the cycle after fs:
  - oTHRESH = iMODE ? auto_th : man_th.
  - oUPDATE = 1 for exactly that cycle.
- Same-cycle collisions:
  - An auto_th written in the DONE cycle that coincides with fs is visible to that fs load.
  - A man_th key event in the fs cycle is not visible; it applies at the next frame.
- Latency: oMEAN/auto_th are valid SUM_W+2 cycles after fe. The result takes effect at the following frame start.
- Reset mid-operation restores all reset values immediately; no partial result survives.

Decomposition:
- Package threshold_ctrl_pkg:
  - state enum {IDLE, ACCUM, DIVIDE, DONE}
  - PIX_W = 12, TH_MAX = 4095, default INIT_TH/STEP
  - clamp function for the 14-bit signed → 12-bit result
- Sub-module seq_divider: unsigned restoring divider.
  - Parameters: SUM_W, CNT_W.
  - Ports: iCLK, iRST, start, abort, dividend, divisor, busy, done, quotient.
  - Timing: one quotient bit per cycle.

Test Plan:
- Reset → oTHRESH = 947, oMEAN = 0, oUPDATE = 0; with no frames, outputs hold indefinitely.
- Manual mode (iMODE = 0): 3 UP pulses, then fs → oTHRESH = 995 with a single oUPDATE pulse. DN pulses from 10 with STEP = 16 → saturates at 0. UP+DN in the same cycle → no change.
- Auto mode (iMODE = 1), OFFSET = 0: frame with pixels 100, 200, 300, 400 → oMEAN = 250 at SUM_W+2 cycles after fe; next fs → oTHRESH = 250.
- Clamping: all pixels 4095 with OFFSET = +64 → oTHRESH = 4095. All pixels 10 with OFFSET = -64 → oTHRESH = 0.
- Empty frame (iFVAL high, iDVAL never) → no divide, oBUSY stays 0; next fs reloads the previous auto_th unchanged.
- fs asserted 5 cycles after fe (mid-DIVIDE) → divide aborted, auto_th keeps its old value, new frame accumulates correctly. Also: iRST pulsed mid-DIVIDE → all reset values restored, oTHRESH = 947.
